// File: rtl/im_loader.sv
// rtl/im_loader.sv - byte-serial program loader feeding the instruction-memory write port
// Assembles big-endian words from a length/data/XOR-checksum frame and releases the core on a good load.
module im_loader #(
  parameter int IM_DEPTH = 1024,
  parameter int ADDR_W   = 16
) (
  input  logic              CLK,
  input  logic              RST_F,
  input  logic              START,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_VALID,
  output logic              RX_READY,
  output logic              IM_WE,
  output logic [ADDR_W-1:0] IM_WADDR,
  output logic [31:0]       IM_WDATA,
  output logic              CPU_RST_F,
  output logic              DONE,
  output logic              ERR,
  output logic [ADDR_W-1:0] WORDS_LOADED
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WR,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] len_q;
  logic [15:0] len_rx;
  logic [7:0]  csum_q;
  logic [1:0]  byte_idx;
  logic [23:0] shift_q;
  logic        xfer;
  logic        start_ok;
  logic        last_word;

  function automatic logic rx_state(input state_t s);
    return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA) || (s == S_CSUM);
  endfunction

  assign xfer      = RX_VALID && RX_READY;
  assign len_rx    = {len_q[15:8], RX_DATA};
  assign start_ok  = START && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  // The word being written in WR is the last one when the post-increment count reaches N.
  assign last_word = (32'(WORDS_LOADED) + 32'd1) == {16'd0, len_q};

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (START) state_nxt = S_LEN_HI;
      S_LEN_HI: if (xfer) state_nxt = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if ({16'd0, len_rx} > 32'(IM_DEPTH)) state_nxt = S_ERR;
          else if (len_rx == 16'd0)            state_nxt = S_CSUM;
          else                                 state_nxt = S_DATA;
        end
      end
      S_DATA:   if (xfer && (byte_idx == 2'd3)) state_nxt = S_WR;
      S_WR:     state_nxt = last_word ? S_CSUM : S_DATA;
      S_CSUM:   if (xfer) state_nxt = (RX_DATA == csum_q) ? S_DONE : S_ERR;
      S_DONE:   if (START) state_nxt = S_LEN_HI;
      S_ERR:    if (START) state_nxt = S_LEN_HI;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      RX_READY     <= 1'b0;
      IM_WE        <= 1'b0;
      IM_WADDR     <= '0;
      IM_WDATA     <= 32'd0;
      CPU_RST_F    <= 1'b0;
      DONE         <= 1'b0;
      ERR          <= 1'b0;
      WORDS_LOADED <= '0;
      len_q        <= 16'd0;
      csum_q       <= 8'd0;
      byte_idx     <= 2'd0;
      shift_q      <= 24'd0;
    end else begin
      RX_READY  <= rx_state(state_nxt);
      IM_WE     <= (state_nxt == S_WR);
      DONE      <= (state_nxt == S_DONE);
      CPU_RST_F <= (state_nxt == S_DONE);
      ERR       <= (state_nxt == S_ERR);

      if (start_ok) begin
        WORDS_LOADED <= '0;
        IM_WADDR     <= '0;
        csum_q       <= 8'd0;
      end

      // The checksum byte itself is compared, never folded into the accumulator.
      if (xfer && (state != S_CSUM)) begin
        csum_q <= csum_q ^ RX_DATA;
      end

      if (xfer && (state == S_LEN_HI)) begin
        len_q[15:8] <= RX_DATA;
      end

      if (xfer && (state == S_LEN_LO)) begin
        len_q[7:0] <= RX_DATA;
        byte_idx   <= 2'd0;
      end

      if (xfer && (state == S_DATA)) begin
        shift_q  <= {shift_q[15:0], RX_DATA};
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) begin
          IM_WDATA <= {shift_q, RX_DATA};
        end
      end

      if (state == S_WR) begin
        IM_WADDR     <= IM_WADDR + ADDR_W'(1);
        WORDS_LOADED <= WORDS_LOADED + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - directed table-driven bench for im_loader
module tb_im_loader;

  localparam int IM_DEPTH = 1024;
  localparam int ADDR_W   = 16;

  logic              CLK = 1'b0;
  logic              RST_F = 1'b1;
  logic              START = 1'b0;
  logic [7:0]        RX_DATA = 8'd0;
  logic              RX_VALID = 1'b0;
  logic              RX_READY;
  logic              IM_WE;
  logic [ADDR_W-1:0] IM_WADDR;
  logic [31:0]       IM_WDATA;
  logic              CPU_RST_F;
  logic              DONE;
  logic              ERR;
  logic [ADDR_W-1:0] WORDS_LOADED;

  im_loader #(.IM_DEPTH(IM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST_F(RST_F), .START(START), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .RX_READY(RX_READY), .IM_WE(IM_WE), .IM_WADDR(IM_WADDR), .IM_WDATA(IM_WDATA),
    .CPU_RST_F(CPU_RST_F), .DONE(DONE), .ERR(ERR), .WORDS_LOADED(WORDS_LOADED)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  csum;
    int          stall;
    logic        exp_done;
    logic        exp_err;
    int          exp_writes;
  } vec_t;

  vec_t vecs[5];
  int   tests = 0;
  int   fails = 0;
  int   we_long = 0;
  logic prev_we = 1'b0;
  logic [47:0] wr_log[$];

  always @(negedge CLK) begin
    if (IM_WE) wr_log.push_back({IM_WADDR, IM_WDATA});
    if (IM_WE && prev_we) we_long++;
    prev_we = IM_WE;
  end

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    int cnt;
    repeat (stall) begin
      @(posedge CLK);
      #1;
    end
    RX_DATA  = b;
    RX_VALID = 1'b1;
    cnt = 0;
    forever begin
      @(negedge CLK);
      if (RX_READY) break;
      cnt++;
      if (cnt > 200) break;
    end
    if (cnt > 200) check("rx_ready_timeout", 48'd1, 48'd0);
    @(posedge CLK);
    #1;
    RX_VALID = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge CLK);
    #1;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    @(negedge CLK);
    check("start_done_low", {47'd0, DONE}, 48'd0);
    check("start_err_low", {47'd0, ERR}, 48'd0);
    check("start_cpu_rst_low", {47'd0, CPU_RST_F}, 48'd0);
    check("start_rx_ready", {47'd0, RX_READY}, 48'd1);
    check("start_words_clear", {32'd0, WORDS_LOADED}, 48'd0);
    @(posedge CLK);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input int stall);
    send_byte(w[31:24], stall);
    send_byte(w[23:16], stall);
    send_byte(w[15:8], stall);
    send_byte(w[7:0], stall);
  endtask

  task automatic run_vec(input vec_t v);
    wr_log.delete();
    pulse_start();
    send_byte(v.n[15:8], v.stall);
    send_byte(v.n[7:0], v.stall);
    if (v.n >= 16'd1) send_word(v.w0, v.stall);
    if (v.n >= 16'd2) send_word(v.w1, v.stall);
    send_byte(v.csum, v.stall);
    repeat (2) @(negedge CLK);
    check("done", {47'd0, DONE}, {47'd0, v.exp_done});
    check("cpu_rst_f", {47'd0, CPU_RST_F}, {47'd0, v.exp_done});
    check("err", {47'd0, ERR}, {47'd0, v.exp_err});
    check("words_loaded", {32'd0, WORDS_LOADED}, {32'd0, v.n});
    check("rx_ready_idle", {47'd0, RX_READY}, 48'd0);
    check("write_count", 48'(wr_log.size()), 48'(v.exp_writes));
    if (wr_log.size() >= 1) check("write0", wr_log[0], {16'd0, v.w0});
    if (wr_log.size() >= 2) check("write1", wr_log[1], {16'd1, v.w1});
    @(posedge CLK);
    #1;
  endtask

  task automatic async_reset();
    @(negedge CLK);
    #2;
    RST_F = 1'b0;
    #1;
    check("rst_rx_ready", {47'd0, RX_READY}, 48'd0);
    check("rst_im_we", {47'd0, IM_WE}, 48'd0);
    check("rst_waddr", {32'd0, IM_WADDR}, 48'd0);
    check("rst_wdata", {16'd0, IM_WDATA}, 48'd0);
    check("rst_cpu_rst_f", {47'd0, CPU_RST_F}, 48'd0);
    check("rst_done", {47'd0, DONE}, 48'd0);
    check("rst_err", {47'd0, ERR}, 48'd0);
    check("rst_words", {32'd0, WORDS_LOADED}, 48'd0);
    repeat (2) @(negedge CLK);
    RST_F = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // csum 02 = 00^02^12^34^56^78^9A^BC^DE^F0 ; 23 = 00^01^DE^AD^BE^EF
    vecs[0] = '{16'd2, 32'h12345678, 32'h9ABCDEF0, 8'h02, 0, 1'b1, 1'b0, 2};
    vecs[1] = '{16'd2, 32'h12345678, 32'h9ABCDEF0, 8'hFD, 0, 1'b0, 1'b1, 2};
    vecs[2] = '{16'd0, 32'h00000000, 32'h00000000, 8'h00, 0, 1'b1, 1'b0, 0};
    vecs[3] = '{16'd2, 32'h12345678, 32'h9ABCDEF0, 8'h02, 3, 1'b1, 1'b0, 2};
    vecs[4] = '{16'd1, 32'hDEADBEEF, 32'h00000000, 8'h23, 1, 1'b1, 1'b0, 1};

    async_reset();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Oversize length aborts before any write and never reopens the stream.
    wr_log.delete();
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    RX_VALID = 1'b1;
    RX_DATA  = 8'h55;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("oversize_rx_ready", {47'd0, RX_READY}, 48'd0);
    end
    RX_VALID = 1'b0;
    check("oversize_err", {47'd0, ERR}, 48'd1);
    check("oversize_done", {47'd0, DONE}, 48'd0);
    check("oversize_cpu_rst", {47'd0, CPU_RST_F}, 48'd0);
    check("oversize_writes", 48'(wr_log.size()), 48'd0);
    @(posedge CLK);
    #1;

    // Length exactly IM_DEPTH is legal: stream stays open for data.
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    @(negedge CLK);
    check("maxlen_err", {47'd0, ERR}, 48'd0);
    check("maxlen_rx_ready", {47'd0, RX_READY}, 48'd1);
    async_reset();

    // Reset after the 6th data byte, then a clean reload.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'h12345678, 0);
    send_byte(8'h9A, 0);
    send_byte(8'hBC, 0);
    wr_log.delete();
    async_reset();
    repeat (4) @(posedge CLK);
    #1;
    check("midrst_no_writes", 48'(wr_log.size()), 48'd0);
    run_vec(vecs[0]);

    check("we_pulse_width", 48'(we_long), 48'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
